score_digit_renderer: RTL and testbench

//  Drives the 0-9 glyph ROM (16 rows x 8 px per digit, address = digit*16 + row, bit 7 = leftmost

---
 rtl/score_digit_renderer.sv | 133 +++++++++++++
 tb/tb_score_digit_renderer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_renderer.sv
// Score digit renderer: serial double-dabble of the game score once per frame,
// then a two-stage glyph ROM lookup that yields a registered pixel_on.
module score_digit_renderer #(
  parameter int DIGITS     = 4,
  parameter int SCORE_W    = 14,
  parameter int X0         = 16,
  parameter int Y0         = 8,
  parameter int LEAD_BLANK = 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [7:0]         rom_addr,
  input  logic [7:0]         rom_data,
  output logic               pixel_on,
  output logic               busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);
  localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);
  localparam logic [SCORE_W-1:0] MAXS = MAXV[SCORE_W-1:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [SCORE_W-1:0] r_shift;
  logic [BW-1:0]      r_bcd;
  logic [BW-1:0]      r_disp;
  logic [SCORE_W-1:0] w_cap;
  logic [BW-1:0]      w_adj;

  always_comb begin
    w_cap = score;
    if (32'(score) > MAXV) w_cap = MAXS;
  end

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_disp  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_shift <= w_cap;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd   <= {w_adj[BW-2:0], r_shift[SCORE_W-1]};
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(SCORE_W - 1)) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_disp  <= r_bcd;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_CONV);

  logic [9:0] w_dx;
  logic [3:0] w_row;
  logic [6:0] w_idx;
  logic [2:0] w_col;
  logic       w_in;
  logic [3:0] w_dig;
  logic       w_bsel;
  logic       w_zero;

  // Range checks come first so DrawX < X0 never wraps into the field.
  assign w_in = (DrawX >= 10'(X0)) && (DrawX < 10'(X0 + 8 * DIGITS))
             && (DrawY >= 10'(Y0)) && (DrawY < 10'(Y0 + 16));
  assign w_dx  = DrawX - 10'(X0);
  assign w_row = DrawY[3:0] - 4'(Y0);
  assign w_idx = w_dx[9:3];
  assign w_col = w_dx[2:0];

  always_comb begin
    w_dig  = '0;
    w_bsel = 1'b0;
    w_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_zero = w_zero & (r_disp[4*(DIGITS-1-i) +: 4] == 4'd0);
      if (w_idx == 7'(i)) begin
        w_dig  = r_disp[4*(DIGITS-1-i) +: 4];
        w_bsel = (LEAD_BLANK != 0) && (i != DIGITS - 1) && w_zero;
      end
    end
  end

  logic [2:0] r_col;
  logic       r_vis;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      r_col    <= '0;
      r_vis    <= 1'b0;
      pixel_on <= 1'b0;
    end else begin
      if (w_in) rom_addr <= {w_dig, w_row};
      r_col    <= w_col;
      r_vis    <= w_in & ~w_bsel;
      pixel_on <= r_vis & rom_data[3'd7 - r_col];
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer; a synthetic glyph ROM returns the
// address itself as row data, except row 2 of every glyph which is 8'h7C.
module tb_score_digit_renderer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [13:0] score = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        pixel_on;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 Clk = ~Clk;

  score_digit_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .score(score), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .busy(busy)
  );

  typedef struct {
    int sc;
    int x;
    int y;
    int addr;
    int pix;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic probe(input int x, input int y, output int a, output int p);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk); #1 a = int'(rom_addr);
    @(posedge Clk); #1 p = int'(pixel_on);
  endtask

  task automatic convert(input int sc, output int cyc);
    score = 14'(sc);
    frame_start = 1'b1;
    @(posedge Clk); #1 frame_start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge Clk); #1;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    int a, p, c, cur, lit;
    int sweep_exp[8];
    int t5_exp[4];

    for (int i = 0; i < 256; i++)
      rom[i] = (i % 16 == 2) ? 8'h7C : 8'(i);

    tbl[0]  = '{1234, 24, 10,  34, 0};
    tbl[1]  = '{1234, 25, 10,  34, 1};
    tbl[2]  = '{1234, 16,  8,  16, 0};
    tbl[3]  = '{1234, 19,  8,  16, 1};
    tbl[4]  = '{1234, 41, 13,  69, 1};
    tbl[5]  = '{1234, 37, 23,  63, 1};
    tbl[6]  = '{1234, 15, 10,  63, 0};
    tbl[7]  = '{1234, 48, 10,  63, 0};
    tbl[8]  = '{1234, 25, 24,  63, 0};
    tbl[9]  = '{1234, 25,  7,  63, 0};
    tbl[10] = '{1234,  0, 10,  63, 0};
    tbl[11] = '{8888, 16, 10, 130, 0};
    tbl[12] = '{8888, 17, 10, 130, 1};
    tbl[13] = '{8888, 15, 10, 130, 0};
    tbl[14] = '{8888, 48, 10, 130, 0};
    tbl[15] = '{8888, 17, 24, 130, 0};
    tbl[16] = '{8888, 45, 23, 143, 1};

    sweep_exp = '{0, 1, 1, 1, 1, 1, 0, 0};
    t5_exp    = '{64, 48, 32, 16};

    // reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pix", int'(pixel_on), 0);
    chk("rst_addr", int'(rom_addr), 0);
    Reset_n = 1'b1;

    // reset in the middle of a conversion
    DrawX = 10'd45;
    DrawY = 10'd13;
    score = 14'd1234;
    frame_start = 1'b1;
    @(posedge Clk); #1 frame_start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("t1_busy_mid", int'(busy), 1);
    chk("t1_pix_pre", int'(pixel_on), 1);
    chk("t1_addr_pre", int'(rom_addr), 5);
    #2 Reset_n = 1'b0;
    #1;
    chk("t1_busy_rst", int'(busy), 0);
    chk("t1_pix_rst", int'(pixel_on), 0);
    chk("t1_addr_rst", int'(rom_addr), 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    probe(45, 13, a, p);
    chk("t1_units_addr", a, 5);
    chk("t1_units_pix", p, 1);
    probe(21, 13, a, p);
    chk("t1_blank_pix", p, 0);
    chk("t1_busy_after", int'(busy), 0);

    // score 1234: conversion length and pipelined sweep
    convert(1234, c);
    chk("t2_busy_len", c, 14);
    DrawY = 10'd10;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) chk("t2_sweep_addr", int'(rom_addr), 34);
      if (i >= 2)
        chk($sformatf("t2_sweep_%0d", i - 2), int'(pixel_on), sweep_exp[i-2]);
      if (i < 8) DrawX = 10'(24 + i);
      @(posedge Clk); #1;
    end

    // raster vector table
    cur = 1234;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].sc != cur) begin
        convert(tbl[i].sc, c);
        chk($sformatf("tbl_busy_len_%0d", i), c, 14);
        cur = tbl[i].sc;
      end
      probe(tbl[i].x, tbl[i].y, a, p);
      chk($sformatf("tbl_addr_%0d", i), a, tbl[i].addr);
      chk($sformatf("tbl_pix_%0d", i), p, tbl[i].pix);
    end

    // saturation
    convert(12000, c);
    for (int d = 0; d < 4; d++) begin
      probe(16 + 8 * d, 8, a, p);
      chk($sformatf("t3_sat_digit_%0d", d), a, 144);
    end

    // leading zero blanking
    convert(7, c);
    for (int d = 0; d < 3; d++) begin
      lit = 0;
      for (int r = 0; r < 16; r++)
        for (int k = 0; k < 8; k++) begin
          probe(16 + 8 * d + k, 8 + r, a, p);
          lit += p;
        end
      chk($sformatf("t4_blank_lit_%0d", d), lit, 0);
    end
    probe(40, 13, a, p);
    chk("t4_units_addr", a, 117);

    // frame_start and score change during conversion are ignored
    score = 14'd4321;
    frame_start = 1'b1;
    @(posedge Clk); #1 frame_start = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      c++;
      if (c == 5) begin
        score = 14'd55;
        frame_start = 1'b1;
      end else begin
        frame_start = 1'b0;
      end
      @(posedge Clk); #1;
    end
    frame_start = 1'b0;
    @(posedge Clk); #1;
    chk("t5_busy_len", c, 14);
    for (int d = 0; d < 4; d++) begin
      probe(16 + 8 * d, 8, a, p);
      chk($sformatf("t5_digit_%0d", d), a, t5_exp[d]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
